// File: rtl/hamming_decoder_pipe_if.sv
// Stream bundle for the (15,11) Hamming decoder: codeword input channel and
// corrected-data output channel, each with a valid/ready handshake.
`timescale 1ns/1ps
interface hamming_decoder_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] decoder_in;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] decoder_out;
    logic [3:0]  syndrome;
    logic        err_det;

    modport master (
        output in_valid, decoder_in, out_ready,
        input  in_ready, out_valid, decoder_out, syndrome, err_det
    );

    modport slave (
        input  in_valid, decoder_in, out_ready,
        output in_ready, out_valid, decoder_out, syndrome, err_det
    );
endinterface

// File: rtl/hamming_decoder_pipe.sv
// Two-stage pipelined (15,11) Hamming single-error-correcting decoder with
// valid/ready flow control and a saturating count of corrected words.
`timescale 1ns/1ps
module hamming_decoder_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hamming_decoder_pipe_if.slave bus,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     corr_cnt
);
    logic [14:0]      s1_word_q;
    logic             s1_vld_q;
    logic [3:0]       s1_syn;
    logic [10:0]      s1_data;

    logic             out_valid_q;
    logic [10:0]      dout_q;
    logic [3:0]       syn_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s2_adv;
    logic             in_xfer;
    logic             out_xfer;

    always_comb begin
        s2_adv   = s1_vld_q && (!out_valid_q || bus.out_ready);
        in_xfer  = bus.in_valid && bus.in_ready;
        out_xfer = out_valid_q && bus.out_ready;
    end

    assign bus.in_ready    = !s1_vld_q || s2_adv;
    assign bus.out_valid   = out_valid_q;
    assign bus.decoder_out = dout_q;
    assign bus.syndrome    = syn_q;
    assign bus.err_det     = err_q;
    assign corr_cnt        = cnt_q;

    // Each mask selects codeword indices whose Hamming position has bit K-1 set.
    always_comb begin
        s1_syn[0] = ^(s1_word_q & 15'h5555);
        s1_syn[1] = ^(s1_word_q & 15'h6666);
        s1_syn[2] = ^(s1_word_q & 15'h7878);
        s1_syn[3] = ^(s1_word_q & 15'h7F80);
    end

    // Only data positions are extracted, so a flipped parity bit never reaches the output.
    always_comb begin
        int j;
        s1_data = '0;
        j = 0;
        for (int i = 0; i < 15; i++) begin
            if ((((i + 1) & i)) != 0) begin
                s1_data[j] = s1_word_q[i] ^ (s1_syn == 4'(i + 1));
                j++;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_word_q <= '0;
            s1_vld_q  <= 1'b0;
        end else if (in_xfer) begin
            s1_word_q <= bus.decoder_in;
            s1_vld_q  <= 1'b1;
        end else if (s2_adv) begin
            s1_vld_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            syn_q       <= '0;
            err_q       <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= 1'b1;
            dout_q      <= s1_data;
            syn_q       <= s1_syn;
            err_q       <= (s1_syn != 4'd0);
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (out_xfer && err_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule
